i2c_scl_gen: RTL and testbench
==============================

Name: i2c_scl_gen

Overview:
- Parametrised I2C SCL clock generator, successor to the free-running clk-to-SCL pulse driver.
- Drives an open-drain `scl` with a runtime-programmable half-period. Supports slave clock stretching with a timeout, and releases the bus cleanly when disabled.
- Gives the I2C master phase strobes (drive/sample) and a per-frame bit counter, so the master no longer derives timing from the system clock.

Parameters:
- DIV_WIDTH, 8, width of `half_period`.
- BITS_PER_FRAME, 9, SCL pulses per frame (8 data + ACK).
- STRETCH_MAX, 1023, max clk cycles spent waiting for a released SCL to read high before a timeout.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run request; 1 = generate SCL, 0 = finish the current pulse, then release.
- half_period  input  DIV_WIDTH  clk cycles per SCL low phase and per SCL high phase; sampled at each LOW entry; value 0 is treated as 1.
- scl  inout  1  open-drain SCL; driven 0 or high-Z, never driven 1 (bus pull-up).
- busy  output  1  high whenever state != IDLE.
- drive_stb  output  1  one-cycle pulse in the first cycle of LOW; master may change SDA.
- sample_stb  output  1  one-cycle pulse in the first cycle of HIGH; master/slave sample SDA.
- bit_cnt  output  4  index of the current SCL pulse within the frame, 0..BITS_PER_FRAME-1.
- frame_stb  output  1  one-cycle pulse when the bit_cnt==BITS_PER_FRAME-1 pulse completes.
- stretching  output  1  high while in WAIT_HI and the synchronised SCL is low.
- timeout  output  1  one-cycle pulse when STRETCH_MAX is reached.

Behaviour:
- Reset values:
  - state = IDLE, scl released (Z).
  - busy, drive_stb, sample_stb, frame_stb, stretching, timeout = 0.
  - bit_cnt = 0, counters = 0, synchroniser = 1.
- SCL input path: 2-flop synchroniser (`scl_s`).
- IDLE:
  - scl released.
  - en=1 -> LOW next edge; latch `hp` = max(half_period,1); load cnt = hp-1; bit_cnt = 0.
- LOW:
  - scl driven 0; drive_stb=1 on the entry cycle only.
  - cnt decrements; at cnt==0 -> WAIT_HI, release scl, clear stretch counter.
  - Low phase lasts exactly `hp` clk cycles.
- WAIT_HI:
  - scl released; stretch counter increments each cycle.
  - `scl_s`==1 -> HIGH, load cnt = hp-1.
  - Minimum dwell is 2 cycles (sync latency) with no stretching.
  - Stretch counter reaching STRETCH_MAX -> timeout pulse, go to IDLE; bit_cnt is held until the next start.
- HIGH:
  - scl released; sample_stb=1 on the entry cycle.
  - cnt decrements; at cnt==0:
    - If bit_cnt==BITS_PER_FRAME-1: frame_stb=1, bit_cnt <= 0. Otherwise bit_cnt += 1.
    - Then en=1 -> LOW (relatch half_period); en=0 -> IDLE.
- Unstretched SCL period = 2*hp + 2 clk cycles.
- en deasserted in LOW or WAIT_HI:
  - Ignored until the HIGH phase completes.
  - No pulse is truncated, and SCL always ends high.
- half_period changes mid-phase have no effect until the next LOW entry.
- A slave pulling SCL low during HIGH is not arbitrated; HIGH runs to completion. Arbitration is the master's responsibility.
- Async reset mid-operation:
  - scl releases immediately (combinational from the state register).
  - All strobes drop to 0.
- Strobes are mutually exclusive within a cycle, except frame_stb, which may coincide with the transition edge only.

Test Plan:
- Basic period: reset pulse, then half_period=4, en=1, no stretch -> SCL low 4 cycles / high 6 cycles (incl. 2 wait); period 10; drive_stb and sample_stb once per period.
- Frame counting: half_period=2, en=1 for 20 SCL pulses -> bit_cnt steps 0..8 and wraps; frame_stb fires on pulses 9 and 18; no pulse otherwise.
- Clock stretch: slave holds SCL low 15 cycles after release, STRETCH_MAX=1023 -> stretching=1 during the hold; HIGH entered 2 cycles after release; sample_stb delayed accordingly; no timeout.
- Stretch timeout: STRETCH_MAX=1023 (default), slave holds SCL low permanently -> timeout pulses exactly once after 1023 WAIT_HI cycles; busy drops; scl released.
- Graceful stop: deassert en in the 2nd cycle of LOW (half_period=4) -> the pulse completes the full low and high phases, then IDLE with SCL high; no further drive_stb.
- Async reset mid-LOW and zero divider: assert reset while SCL is low -> SCL high-Z within the same cycle, all outputs at reset values. Then half_period=0 -> behaves as half_period=1 (period 4).

Source files
------------

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: open-drain SCL with programmable half-period, clock stretching with
// timeout, drive/sample phase strobes and a per-frame bit counter for the master.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | SCL released, waiting for en
// LOW     | SCL driven low for hp cycles
// WAIT_HI | SCL released, waiting for the bus to read high (slave stretch)
// HIGH    | SCL released high for hp cycles, then next pulse or IDLE
module i2c_scl_gen #(
    parameter int DIV_WIDTH      = 8,
    parameter int BITS_PER_FRAME = 9,
    parameter int STRETCH_MAX    = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] half_period,
    inout  wire                  scl,
    output logic                 busy,
    output logic                 drive_stb,
    output logic                 sample_stb,
    output logic [3:0]           bit_cnt,
    output logic                 frame_stb,
    output logic                 stretching,
    output logic                 timeout
);

    localparam int                   SW           = $clog2(STRETCH_MAX + 1);
    localparam logic [SW-1:0]        STRETCH_LAST = SW'(STRETCH_MAX - 1);
    localparam logic [3:0]           LAST_BIT     = 4'(BITS_PER_FRAME - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE      = DIV_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, LOW, WAIT_HI, HIGH} state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_hp;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [SW-1:0]        r_stretch;
    logic                 r_scl_meta;
    logic                 r_scl_s;
    logic                 r_drive_stb;
    logic                 r_sample_stb;
    logic                 r_frame_stb;
    logic                 r_timeout;
    logic [3:0]           r_bit_cnt;
    logic [DIV_WIDTH-1:0] w_hp_next;

    assign w_hp_next = (half_period == '0) ? DIV_ONE : half_period;

    // Release is decoded straight from the state register so reset frees the bus at once.
    assign scl        = (r_state == LOW) ? 1'b0 : 1'bz;
    assign busy       = (r_state != IDLE);
    assign stretching = (r_state == WAIT_HI) && !r_scl_s;
    assign drive_stb  = r_drive_stb;
    assign sample_stb = r_sample_stb;
    assign frame_stb  = r_frame_stb;
    assign timeout    = r_timeout;
    assign bit_cnt    = r_bit_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_s    <= 1'b1;
        end else begin
            r_scl_meta <= scl;
            r_scl_s    <= r_scl_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hp         <= '0;
            r_cnt        <= '0;
            r_stretch    <= '0;
            r_bit_cnt    <= '0;
            r_drive_stb  <= 1'b0;
            r_sample_stb <= 1'b0;
            r_frame_stb  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_drive_stb  <= 1'b0;
            r_sample_stb <= 1'b0;
            r_frame_stb  <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state     <= LOW;
                        r_hp        <= w_hp_next;
                        r_cnt       <= w_hp_next - DIV_ONE;
                        r_bit_cnt   <= '0;
                        r_drive_stb <= 1'b1;
                    end
                end
                LOW: begin
                    if (r_cnt == '0) begin
                        r_state   <= WAIT_HI;
                        r_stretch <= '0;
                    end else begin
                        r_cnt <= r_cnt - DIV_ONE;
                    end
                end
                WAIT_HI: begin
                    // Leave on the edge where scl_s takes the high level, giving a 2-cycle dwell.
                    if (r_scl_meta) begin
                        r_state      <= HIGH;
                        r_cnt        <= r_hp - DIV_ONE;
                        r_sample_stb <= 1'b1;
                    end else if (r_stretch == STRETCH_LAST) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_stretch <= r_stretch + SW'(1);
                    end
                end
                HIGH: begin
                    if (r_cnt == '0) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_frame_stb <= 1'b1;
                            r_bit_cnt   <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                        if (en) begin
                            r_state     <= LOW;
                            r_hp        <= w_hp_next;
                            r_cnt       <= w_hp_next - DIV_ONE;
                            r_drive_stb <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: randomized bursts checked cycle by cycle against a per-pulse
// timing model (low hp, wait 2+hold, high hp) with a pulled-up SCL and a stretching slave.
module tb_i2c_scl_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] half_period;
    logic       slave_hold;
    wire        scl_bus;
    logic       busy, drive_stb, sample_stb, frame_stb, stretching, timeout;
    logic [3:0] bit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pullup (scl_bus);
    assign scl_bus = slave_hold ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_scl_gen #(
        .DIV_WIDTH(8),
        .BITS_PER_FRAME(9),
        .STRETCH_MAX(1023)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .half_period(half_period),
        .scl(scl_bus),
        .busy(busy),
        .drive_stb(drive_stb),
        .sample_stb(sample_stb),
        .bit_cnt(bit_cnt),
        .frame_stb(frame_stb),
        .stretching(stretching),
        .timeout(timeout)
    );

    // {scl, busy, drive, sample, frame, stretching, timeout, bit_cnt}
    wire [10:0] obs = {scl_bus, busy, drive_stb, sample_stb, frame_stb, stretching, timeout, bit_cnt};

    task automatic check(input string tag, input logic [10:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Expected outputs at cycle k of pulse p (hold = cycles the slave keeps SCL low after release).
    function automatic logic [10:0] pulse_exp(input int p, input int k, input int h, input int hold);
        int   w;
        logic sclv, drv, smp, frm, str;
        w    = hold + 2;
        sclv = !((k < h) || (hold > 0 && k >= h && k <= h + hold));
        drv  = (k == 0);
        smp  = (k == h + w);
        frm  = (k == 0) && (p > 0) && (p % 9 == 0);
        // synchronised SCL lags the bus by two edges; the bus was low at edges 0 .. h+hold-1
        str  = (k >= h) && (k < h + w) && (k >= 2) && (k - 2 < h + hold);
        return {sclv, 1'b1, drv, smp, frm, str, 1'b0, 4'(p % 9)};
    endfunction

    function automatic logic [10:0] idle_exp(input logic sclv, input logic frm, input logic tmo, input int bc);
        return {sclv, 1'b0, 1'b0, 1'b0, frm, 1'b0, tmo, 4'(bc)};
    endfunction

    task automatic run_burst(input int n, input int hp_lo, input int hp_hi, input int s_hi,
                             input bit keep_en, input string tag);
        int hraw[];
        int hh[];
        int ss[];
        int stop_off;
        int len;
        hraw = new[n];
        hh   = new[n];
        ss   = new[n];
        for (int p = 0; p < n; p++) begin
            hraw[p] = int'($urandom_range(hp_hi, hp_lo));
            hh[p]   = (hraw[p] == 0) ? 1 : hraw[p];
            if (s_hi == 0) ss[p] = 0;
            else ss[p] = ($urandom_range(1, 0) == 1) ? s_hi : int'($urandom_range(s_hi, 0));
        end
        stop_off = int'($urandom_range(hh[n-1] - 1, 0));
        @(negedge clk);
        en          = 1'b1;
        half_period = 8'(hraw[0]);
        for (int p = 0; p < n; p++) begin
            len = 2 * hh[p] + ss[p] + 2;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                check(tag, pulse_exp(p, k, hh[p], ss[p]));
                slave_hold = (ss[p] > 0) && (k >= hh[p] - 1) && (k < hh[p] + ss[p]);
                if (k == len - 1) begin
                    half_period = (p < n - 1) ? 8'(hraw[p+1]) : (keep_en ? 8'd4 : 8'($urandom));
                    en          = (p < n - 1) || keep_en;
                end else begin
                    half_period = 8'($urandom_range(255, 0));
                    if (p == n - 1 && !keep_en && k >= stop_off) en = 1'b0;
                end
            end
        end
        if (!keep_en) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check({tag, "_idle"}, idle_exp(1'b1, (j == 0) && (n % 9 == 0), 1'b0, n % 9));
            end
        end
    endtask

    initial begin
        int h;
        reset       = 1'b1;
        en          = 1'b0;
        half_period = 8'd4;
        slave_hold  = 1'b0;

        @(negedge clk);
        check("reset", idle_exp(1'b1, 1'b0, 1'b0, 0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset", idle_exp(1'b1, 1'b0, 1'b0, 0));

        run_burst(3, 4, 4, 0, 1'b0, "basic");
        run_burst(20, 2, 2, 0, 1'b0, "frame");
        run_burst(6, 1, 5, 15, 1'b0, "stretch");
        run_burst(10, 0, 7, 4, 1'b0, "random");
        run_burst(9, 4, 4, 0, 1'b0, "graceful");

        // Slave never releases: timeout after 1023 WAIT_HI cycles.
        h = int'($urandom_range(4, 1));
        @(negedge clk);
        en          = 1'b1;
        half_period = 8'(h);
        for (int k = 0; k < h + 1027; k++) begin
            @(negedge clk);
            if (k < h + 1023) check("timeout_run", pulse_exp(0, k, h, 100000));
            else check("timeout_end", idle_exp(1'b0, 1'b0, k == h + 1023, 0));
            slave_hold  = (k >= h - 1);
            half_period = 8'($urandom_range(255, 0));
            if (k == 0) en = 1'b0;
        end
        slave_hold = 1'b0;
        @(negedge clk);
        check("timeout_release", idle_exp(1'b1, 1'b0, 1'b0, 0));

        // Async reset in the middle of a LOW phase.
        run_burst(5, 1, 3, 0, 1'b1, "pre_rst");
        @(negedge clk);
        check("rst_low0", pulse_exp(5, 0, 4, 0));
        @(negedge clk);
        check("rst_low1", pulse_exp(5, 1, 4, 0));
        #2 reset = 1'b1;
        #1 check("async_rst", idle_exp(1'b1, 1'b0, 1'b0, 0));
        @(negedge clk);
        en     = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check("after_rst", idle_exp(1'b1, 1'b0, 1'b0, 0));

        run_burst(4, 0, 0, 0, 1'b0, "zero_div");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
